// File: rtl/logicnet_input_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : logicnet_input_quantizer
//  Description : Rounds/saturates a stream of signed feature samples to QBITS
//                codes, packs a frame of NUM_FEATURES codes and hands it to
//                layer 0 over valid/ready; detects and resyncs framing errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module logicnet_input_quantizer #(
    parameter int IN_W         = 16,
    parameter int QBITS        = 2,
    parameter int SHIFT        = 6,
    parameter int NUM_FEATURES = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [IN_W-1:0]                 s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [NUM_FEATURES*QBITS-1:0]   m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            err_short,
    output logic                            err_long,
    output logic [7:0]                      err_count
);

    localparam int c_idx_w = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_FEATURES - 1);
    localparam logic signed [IN_W:0] c_round    = (IN_W+1)'(1 << (SHIFT - 1));
    localparam logic signed [IN_W:0] c_code_max = (IN_W+1)'((1 << QBITS) - 1);

    localparam logic [1:0] c_st_collect = 2'd0;
    localparam logic [1:0] c_st_hold    = 2'd1;
    localparam logic [1:0] c_st_drain   = 2'd2;

    logic [1:0]                      r_state;
    logic [c_idx_w-1:0]              r_idx;
    logic [NUM_FEATURES*QBITS-1:0]   r_data;
    logic                            r_valid;
    logic                            r_err_short;
    logic                            r_err_long;
    logic [7:0]                      r_err_count;

    logic signed [IN_W:0]            w_t;
    logic signed [IN_W:0]            w_u;
    logic [QBITS-1:0]                w_code;
    logic                            w_accept;
    logic                            w_at_last;
    logic                            w_short_evt;
    logic                            w_long_evt;

    // One extra bit of headroom keeps the rounding add from overflowing.
    assign w_t = $signed({s_data[IN_W-1], s_data}) + c_round;
    assign w_u = w_t >>> SHIFT;

    always_comb begin
        w_code = '0;
        if (w_u[IN_W]) begin
            w_code = '0;
        end else if (w_u > c_code_max) begin
            w_code = '1;
        end else begin
            w_code = w_u[QBITS-1:0];
        end
    end

    assign s_ready     = (r_state == c_st_collect) || (r_state == c_st_drain);
    assign w_accept    = s_valid && s_ready;
    assign w_at_last   = (r_idx == c_last_idx);
    assign w_short_evt = (r_state == c_st_collect) && w_accept && !w_at_last && s_last;
    assign w_long_evt  = (r_state == c_st_collect) && w_accept && w_at_last && !s_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_collect;
            r_idx       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_err_short <= w_short_evt;
            r_err_long  <= w_long_evt;
            if ((w_short_evt || w_long_evt) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            case (r_state)
                c_st_collect: begin
                    // m_valid is always low here, so writing slots is safe.
                    if (w_accept) begin
                        r_data[r_idx*QBITS +: QBITS] <= w_code;
                        if (w_at_last) begin
                            r_idx   <= '0;
                            r_valid <= 1'b1;
                            r_state <= s_last ? c_st_hold : c_st_drain;
                        end else if (s_last) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_st_hold: begin
                    if (m_ready) begin
                        r_valid <= 1'b0;
                        r_state <= c_st_collect;
                    end
                end
                c_st_drain: begin
                    if (r_valid && m_ready) begin
                        r_valid <= 1'b0;
                    end
                    // Overrun samples are dropped until the frame's s_last shows up.
                    if (w_accept && s_last) begin
                        r_state <= (r_valid && !m_ready) ? c_st_hold : c_st_collect;
                    end
                end
                default: begin
                    r_state <= c_st_collect;
                end
            endcase
        end
    end

    assign m_data    = r_data;
    assign m_valid   = r_valid;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_logicnet_input_quantizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logicnet_input_quantizer
//  Description : Randomised self-checking bench with a frame-level reference
//                model for logicnet_input_quantizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logicnet_input_quantizer;

    localparam int N  = 8;
    localparam int Q  = 2;
    localparam int SH = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [N*Q-1:0]    m_data;
    logic              m_valid;
    logic              m_ready;
    logic              err_short;
    logic              err_long;
    logic [7:0]        err_count;

    logicnet_input_quantizer #(
        .IN_W(16), .QBITS(Q), .SHIFT(SH), .NUM_FEATURES(N)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .err_short(err_short), .err_long(err_long), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model (frame level) ----------------
    int             slot[N];
    int             cnt = 0;
    bit             dropping = 0;
    logic [N*Q-1:0] exp_q[$];
    int             exp_short = 0, exp_long = 0;
    int             seen_short = 0, seen_long = 0;

    function automatic int quant(input int x);
        int t, u, step;
        step = 1 << SH;
        t = x + (step / 2);
        u = (t >= 0) ? t / step : -((-t + step - 1) / step);
        if (u < 0) return 0;
        if (u > (1 << Q) - 1) return (1 << Q) - 1;
        return u;
    endfunction

    function automatic logic [N*Q-1:0] pack_slots();
        logic [N*Q-1:0] v = '0;
        for (int k = 0; k < N; k++) v = v | ((N*Q)'(slot[k]) << (k*Q));
        return v;
    endfunction

    task automatic model_beat(input int x, input bit last);
        if (dropping) begin
            if (last) dropping = 0;
            return;
        end
        slot[cnt] = quant(x);
        if (cnt == N-1) begin
            exp_q.push_back(pack_slots());
            cnt = 0;
            if (!last) begin dropping = 1; exp_long++; end
        end else if (last) begin
            cnt = 0;
            exp_short++;
        end else begin
            cnt++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) slot[k] = 0;
        cnt = 0; dropping = 0; exp_q.delete();
        exp_short = 0; exp_long = 0; seen_short = 0; seen_long = 0;
    endtask

    function automatic int exp_err_count();
        return (exp_short + exp_long > 255) ? 255 : exp_short + exp_long;
    endfunction

    // ---------------- drivers ----------------
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send_beat(input int x, input bit last);
        int guard = 0;
        bit acc   = 0;
        s_data = x[15:0]; s_valid = 1'b1; s_last = last;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = s_ready;
            if (acc) model_beat(x, last);
            @(posedge clk); #1;
            guard++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
    endtask

    function automatic int rnd_sample();
        int corners[9] = '{-32768, 32767, -33, -32, 31, 32, 159, 160, 224};
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return int'($urandom_range(0, 360)) - 60;
            default: return corners[$urandom_range(0, 8)];
        endcase
    endfunction

    task automatic send_frame(input int len, input int last_at);
        for (int i = 0; i < len; i++) send_beat(rnd_sample(), (i == last_at));
    endtask

    // ---------------- output monitor ----------------
    bit             prev_hold = 0;
    logic [N*Q-1:0] prev_data;
    bit             prev_mv = 0;
    bit             measure = 0;
    int             rise_cyc[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_hold = 0; prev_mv = 0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", 64'(m_valid), 64'd1);
                check_eq("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check_eq("vec_expected", 64'(exp_q.size()), 64'd1);
                else check_eq("vec_data", 64'(m_data), 64'(exp_q.pop_front()));
            end
            if (measure && m_valid && !prev_mv) rise_cyc.push_back(cyc);
            if (err_short) seen_short++;
            if (err_long)  seen_long++;
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_mv   = m_valid;
        end
    end

    // ---------------- main sequence ----------------
    int t1[8] = '{0, 32, 64, 95, 96, 160, -5, 32767};

    initial begin
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_data", 64'(m_data), 64'd0);
        check_eq("rst_s_ready", 64'(s_ready), 64'd1);
        check_eq("rst_err_count", 64'(err_count), 64'd0);
        check_eq("rst_err_pulses", 64'({err_short, err_long}), 64'd0);

        // Reference frame with hand-derived codes {0,1,1,1,2,3,0,3}.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_beat(t1[i], (i == 7));
        check_eq("latency_m_valid", 64'(m_valid), 64'd1);
        check_eq("t1_m_data", 64'(m_data), 64'hCE54);

        // Backpressure: vector held, input stalled.
        s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_s_ready", 64'(s_ready), 64'd0);
            check_eq("bp_m_valid", 64'(m_valid), 64'd1);
        end
        s_valid = 1'b0;
        ready_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check_eq("release_m_valid", 64'(m_valid), 64'd0);
        check_eq("release_s_ready", 64'(s_ready), 64'd1);

        // Short frame, then a clean frame.
        @(posedge clk); #1;
        send_frame(3, 2);
        @(negedge clk);
        check_eq("short_pulse", 64'(err_short), 64'd1);
        check_eq("short_count", 64'(err_count), 64'(exp_err_count()));
        @(negedge clk);
        check_eq("short_pulse_end", 64'(err_short), 64'd0);
        @(posedge clk); #1;
        send_frame(8, 7);

        // Long frame: vector after 8th beat, overrun dropped.
        send_frame(8, -1);
        @(negedge clk);
        check_eq("long_pulse", 64'(err_long), 64'd1);
        check_eq("long_count", 64'(err_count), 64'(exp_err_count()));
        @(posedge clk); #1;
        send_frame(3, 2);
        send_frame(8, 7);

        // Reset during beat 5 of a frame.
        send_frame(4, -1);
        s_valid = 1'b1; s_data = 16'h0100; s_last = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("amid_m_valid", 64'(m_valid), 64'd0);
        check_eq("amid_m_data", 64'(m_data), 64'd0);
        check_eq("amid_err_count", 64'(err_count), 64'd0);
        check_eq("amid_s_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(8, 7);
        repeat (3) @(negedge clk);
        check_eq("post_rst_err_count", 64'(err_count), 64'd0);

        // Randomised frames, gaps and backpressure.
        ready_mode = 2;
        @(posedge clk); #1;
        for (int f = 0; f < 60; f++) begin
            int kind = $urandom_range(0, 3);
            if (kind <= 1)      send_frame(8, 7);
            else if (kind == 2) send_frame($urandom_range(1, 7), -2);
            else                send_frame($urandom_range(9, 12), -2);
            if (kind >= 2) send_beat(rnd_sample(), 1'b1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        check_eq("rand_err_count", 64'(err_count), 64'(exp_err_count()));

        // Counter saturation.
        ready_mode = 1;
        for (int f = 0; f < 300; f++) send_beat(rnd_sample(), 1'b1);
        repeat (2) @(negedge clk);
        check_eq("sat_err_count", 64'(err_count), 64'(exp_err_count()));
        check_eq("sat_is_255", 64'(exp_err_count()), 64'd255);

        // Sustained throughput with m_ready held high.
        @(posedge clk); #1;
        measure = 1;
        rise_cyc.delete();
        for (int f = 0; f < 4; f++) send_frame(8, 7);
        repeat (3) @(negedge clk);
        measure = 0;
        check_eq("tput_vectors", 64'(rise_cyc.size()), 64'd4);
        for (int i = 1; i < rise_cyc.size(); i++)
            check_eq("tput_spacing", 64'(rise_cyc[i] - rise_cyc[i-1]), 64'd9);

        // Drain and final bookkeeping.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("final_q_empty", 64'(exp_q.size()), 64'd0);
        check_eq("final_short_pulses", 64'(seen_short), 64'(exp_short));
        check_eq("final_long_pulses", 64'(seen_long), 64'(exp_long));
        check_eq("final_err_count", 64'(err_count), 64'(exp_err_count()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
